// File: rtl/jtdd_adpcm_fetch_pkg.sv
// Shared definitions for the Double Dragon ADPCM fetcher:
// register offsets, channel state encoding and page width.
package jtdd_adpcm_fetch_pkg;

  localparam int PAGE_W = 8;

  localparam logic [2:0] REG_PLAY0  = 3'd0;
  localparam logic [2:0] REG_PLAY1  = 3'd1;
  localparam logic [2:0] REG_STOP0  = 3'd2;
  localparam logic [2:0] REG_STOP1  = 3'd3;
  localparam logic [2:0] REG_END0   = 3'd4;
  localparam logic [2:0] REG_END1   = 3'd5;
  localparam logic [2:0] REG_START0 = 3'd6;
  localparam logic [2:0] REG_START1 = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT_HI,
    ST_WAIT_LO
  } ch_state_e;

endpackage

// File: rtl/jtdd_adpcm_fetch_ch.sv
// One ADPCM channel: pointer, byte buffer and nibble sequencer.
// Ports: play/stop pulses, page regs, vclk strobe, ROM grant -> req/addr, nibble, idle.
module jtdd_adpcm_ch
  import jtdd_adpcm_fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              play_i,
  input  logic              stop_i,
  input  logic [PAGE_W-1:0] start_i,
  input  logic [PAGE_W-1:0] end_i,
  input  logic              vclk_cen_i,
  input  logic              ok_i,
  input  logic [7:0]        rom_data_i,
  output logic              req_o,
  output logic [15:0]       addr_o,
  output logic [3:0]        data_o,
  output logic              idle_o
);

  ch_state_e   state_q, state_d;
  logic [15:0] ptr_q, ptr_d;
  logic [7:0]  buf_q, buf_d;
  logic [3:0]  data_q, data_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      buf_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      buf_q   <= buf_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    buf_d   = buf_q;
    data_d  = data_q;
    if (stop_i) begin
      state_d = ST_IDLE;
    end else if (play_i) begin
      ptr_d   = {start_i, 8'h00};
      state_d = ST_FETCH;
    end else begin
      unique case (state_q)
        ST_FETCH: begin
          // underrun: strobe consumed, silence emitted
          if (vclk_cen_i) data_d = 4'h0;
          if (ok_i) begin
            buf_d   = rom_data_i;
            state_d = ST_WAIT_HI;
          end
        end
        ST_WAIT_HI: begin
          if (vclk_cen_i) begin
            data_d  = buf_q[7:4];
            state_d = ST_WAIT_LO;
          end
        end
        ST_WAIT_LO: begin
          if (vclk_cen_i) begin
            data_d = buf_q[3:0];
            if (ptr_q == {end_i, 8'hFF}) begin
              state_d = ST_IDLE;
            end else begin
              ptr_d   = ptr_q + 16'd1;
              state_d = ST_FETCH;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign req_o  = (state_q == ST_FETCH);
  assign addr_o = ptr_q;
  assign data_o = data_q;
  assign idle_o = (state_q == ST_IDLE);

endmodule

// File: rtl/jtdd_adpcm_fetch.sv
// ADPCM fetcher top: CPU register decode, two channels, ROM arbiter.
// Ports: CPU write bus, vclk strobe, one ROM slot, per-channel nibble/reset, busy.
module jtdd_adpcm_fetch
  import jtdd_adpcm_fetch_pkg::*;
#(
  parameter int AW = 17
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_cen,
  input  logic          adpcm_cs,
  input  logic          cpu_wrn,
  input  logic [2:0]    cpu_AB,
  input  logic [7:0]    cpu_dout,
  input  logic          vclk_cen,
  output logic [AW-1:0] rom_addr,
  output logic          rom_cs,
  input  logic [7:0]    rom_data,
  input  logic          rom_ok,
  output logic [3:0]    snd0_data,
  output logic [3:0]    snd1_data,
  output logic          snd0_rst,
  output logic          snd1_rst,
  output logic [1:0]    busy
);

  logic              wr;
  logic [1:0]        play, stop, cmd;
  logic [1:0]        req, req_m, idle, ok;
  logic [PAGE_W-1:0] start0_q, start1_q;
  logic [PAGE_W-1:0] end0_q, end1_q;
  logic [15:0]       ch_addr0, ch_addr1;
  logic              cs_q, cs_d;
  logic              gnt_q, gnt_d;
  logic              last_q, last_d;
  logic [AW-1:0]     addr_q, addr_d;

  assign wr      = cpu_cen & adpcm_cs & ~cpu_wrn;
  assign play[0] = wr && (cpu_AB == REG_PLAY0);
  assign play[1] = wr && (cpu_AB == REG_PLAY1);
  assign stop[0] = wr && (cpu_AB == REG_STOP0);
  assign stop[1] = wr && (cpu_AB == REG_STOP1);
  assign cmd     = play | stop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start0_q <= '0;
      start1_q <= '0;
      end0_q   <= '0;
      end1_q   <= '0;
    end else if (wr) begin
      case (cpu_AB)
        REG_START0: start0_q <= cpu_dout;
        REG_START1: start1_q <= cpu_dout;
        REG_END0:   end0_q   <= cpu_dout;
        REG_END1:   end1_q   <= cpu_dout;
        default: ;
      endcase
    end
  end

  jtdd_adpcm_ch u_ch0 (
    .clk        (clk),
    .rst        (rst),
    .play_i     (play[0]),
    .stop_i     (stop[0]),
    .start_i    (start0_q),
    .end_i      (end0_q),
    .vclk_cen_i (vclk_cen),
    .ok_i       (ok[0]),
    .rom_data_i (rom_data),
    .req_o      (req[0]),
    .addr_o     (ch_addr0),
    .data_o     (snd0_data),
    .idle_o     (idle[0])
  );

  jtdd_adpcm_ch u_ch1 (
    .clk        (clk),
    .rst        (rst),
    .play_i     (play[1]),
    .stop_i     (stop[1]),
    .start_i    (start1_q),
    .end_i      (end1_q),
    .vclk_cen_i (vclk_cen),
    .ok_i       (ok[1]),
    .rom_data_i (rom_data),
    .req_o      (req[1]),
    .addr_o     (ch_addr1),
    .data_o     (snd1_data),
    .idle_o     (idle[1])
  );

  assign ok[0] = rom_ok & cs_q & ~gnt_q;
  assign ok[1] = rom_ok & cs_q & gnt_q;

  // a channel taking a command this cycle has a stale request
  assign req_m = req & ~cmd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_q   <= 1'b0;
      gnt_q  <= 1'b0;
      last_q <= 1'b1;
      addr_q <= '0;
    end else begin
      cs_q   <= cs_d;
      gnt_q  <= gnt_d;
      last_q <= last_d;
      addr_q <= addr_d;
    end
  end

  always_comb begin
    cs_d   = cs_q;
    gnt_d  = gnt_q;
    last_d = last_q;
    addr_d = addr_q;
    if (cs_q) begin
      if (cmd[gnt_q]) begin
        cs_d = 1'b0;
      end else if (rom_ok) begin
        cs_d   = 1'b0;
        last_d = gnt_q;
      end
    end else if (|req_m) begin
      cs_d = 1'b1;
      if (req_m == 2'b11) gnt_d = ~last_q;
      else                gnt_d = req_m[1];
      addr_d = AW'({gnt_d, gnt_d ? ch_addr1 : ch_addr0});
    end
  end

  assign rom_cs   = cs_q;
  assign rom_addr = addr_q;
  assign snd0_rst = idle[0];
  assign snd1_rst = idle[1];
  assign busy     = ~idle;

endmodule

// File: tb/tb_jtdd_adpcm_fetch.sv
// Self-checking bench for jtdd_adpcm_fetch: ROM responder with
// programmable latency, nibble capture and a playback reference model.
module tb_jtdd_adpcm_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_cen = 1'b0;
  logic        adpcm_cs = 1'b0;
  logic        cpu_wrn = 1'b1;
  logic [2:0]  cpu_AB = '0;
  logic [7:0]  cpu_dout = '0;
  logic        vclk_cen = 1'b0;
  logic [16:0] rom_addr;
  logic        rom_cs;
  logic [7:0]  rom_data = '0;
  logic        rom_ok = 1'b0;
  logic [3:0]  snd0_data, snd1_data;
  logic        snd0_rst, snd1_rst;
  logic [1:0]  busy;

  int          checks = 0;
  int          errors = 0;
  int          lat = 3;
  logic [7:0]  romxor = '0;
  bit          force_ok = 1'b0;

  logic [3:0]  q0[$], q1[$], exp_nib[$];
  logic [16:0] alog[$], exp_addr[$];

  always #5 clk = ~clk;

  jtdd_adpcm_fetch #(.AW(17)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_cen   (cpu_cen),
    .adpcm_cs  (adpcm_cs),
    .cpu_wrn   (cpu_wrn),
    .cpu_AB    (cpu_AB),
    .cpu_dout  (cpu_dout),
    .vclk_cen  (vclk_cen),
    .rom_addr  (rom_addr),
    .rom_cs    (rom_cs),
    .rom_data  (rom_data),
    .rom_ok    (rom_ok),
    .snd0_data (snd0_data),
    .snd1_data (snd1_data),
    .snd0_rst  (snd0_rst),
    .snd1_rst  (snd1_rst),
    .busy      (busy)
  );

  function automatic logic [7:0] rom_byte(input logic [16:0] a);
    return a[7:0] ^ romxor ^ (a[16] ? 8'hA5 : 8'h00);
  endfunction

  function automatic void model(input logic ch, input logic [7:0] s,
                                input logic [7:0] e);
    logic [15:0] a;
    logic [7:0]  b;
    exp_nib.delete();
    exp_addr.delete();
    a = {s, 8'h00};
    for (int i = 0; i < 65536; i++) begin
      exp_addr.push_back({ch, a});
      b = rom_byte({ch, a});
      exp_nib.push_back(b[7:4]);
      exp_nib.push_back(b[3:0]);
      if (a == {e, 8'hFF}) break;
      a = a + 16'd1;
    end
  endfunction

  function automatic int diff4(input logic [3:0] a[$],
                               input logic [3:0] b[$], input int n);
    for (int i = 0; i < n; i++)
      if (i >= a.size() || i >= b.size() || a[i] !== b[i]) return i;
    return -1;
  endfunction

  function automatic int diff17(input logic [16:0] a[$],
                                input logic [16:0] b[$], input int n);
    for (int i = 0; i < n; i++)
      if (i >= a.size() || i >= b.size() || a[i] !== b[i]) return i;
    return -1;
  endfunction

  int          rcnt = 0;
  logic        prev_cs = 1'b0;
  logic [16:0] la = '0;
  always @(negedge clk) begin
    if (rom_cs && prev_cs && rom_addr == la) rcnt++;
    else rcnt = 0;
    prev_cs  = rom_cs;
    la       = rom_addr;
    rom_data = rom_byte(rom_addr);
    rom_ok   = (rom_cs && rcnt >= lat) || force_ok;
    if (rom_cs && rcnt >= lat) alog.push_back(rom_addr);
  end

  always @(posedge clk) begin : cap
    logic       v;
    logic [1:0] b;
    v = vclk_cen;
    b = busy;
    #1;
    if (v && b[0]) q0.push_back(snd0_data);
    if (v && b[1]) q1.push_back(snd1_data);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d,
                    input bit cen = 1'b1);
    @(negedge clk);
    cpu_cen  = cen;
    adpcm_cs = 1'b1;
    cpu_wrn  = 1'b0;
    cpu_AB   = a;
    cpu_dout = d;
    @(negedge clk);
    cpu_cen  = 1'b0;
    adpcm_cs = 1'b0;
    cpu_wrn  = 1'b1;
  endtask

  task automatic strobe();
    @(negedge clk);
    vclk_cen = 1'b1;
    @(negedge clk);
    vclk_cen = 1'b0;
  endtask

  task automatic run_v(input int per, input int maxs, input bit until_idle);
    int c = 0;
    int s = 0;
    while (s < maxs) begin
      @(negedge clk);
      vclk_cen = 1'b0;
      if (until_idle && busy == 2'b00) break;
      vclk_cen = (c == per - 1);
      if (vclk_cen) begin s++; c = 0; end
      else c++;
    end
    @(negedge clk);
    vclk_cen = 1'b0;
  endtask

  task automatic test_reset();
    tick(2);
    checks++;
    if (rom_cs !== 1'b0 || rom_addr !== 17'h0) begin
      errors++;
      $display("FAIL reset_rom cs=%b addr=%h want 0/0", rom_cs, rom_addr);
    end
    checks++;
    if (snd0_rst !== 1'b1 || snd1_rst !== 1'b1 || busy !== 2'b00) begin
      errors++;
      $display("FAIL reset_rst rst=%b%b busy=%b want 11/00",
               snd1_rst, snd0_rst, busy);
    end
    checks++;
    if (snd0_data !== 4'h0 || snd1_data !== 4'h0) begin
      errors++;
      $display("FAIL reset_data %h %h want 0 0", snd0_data, snd1_data);
    end
    @(negedge clk);
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_single();
    int d, da;
    romxor = 8'h00;
    lat    = 3;
    wr(3'd6, 8'h12);
    wr(3'd4, 8'h12);
    q0.delete();
    alog.delete();
    wr(3'd0, 8'h00);
    checks++;
    if (snd0_rst !== 1'b0 || rom_cs !== 1'b0) begin
      errors++;
      $display("FAIL play_edge rst=%b cs=%b want 0/0", snd0_rst, rom_cs);
    end
    @(negedge clk);
    checks++;
    if (rom_cs !== 1'b1 || rom_addr !== 17'h01200) begin
      errors++;
      $display("FAIL first_req cs=%b addr=%h want 1/01200", rom_cs, rom_addr);
    end
    run_v(40, 600, 1'b1);
    model(1'b0, 8'h12, 8'h12);
    d = diff4(q0, exp_nib, exp_nib.size());
    checks++;
    if (d >= 0 || q0.size() != 512) begin
      errors++;
      $display("FAIL single_nibbles idx=%0d got_n=%0d want_n=512", d, q0.size());
    end
    checks++;
    if (q0.size() < 4 || {q0[0], q0[1], q0[2], q0[3]} !== 16'h0001) begin
      errors++;
      $display("FAIL single_first4 n=%0d want 0001", q0.size());
    end
    da = diff17(alog, exp_addr, exp_addr.size());
    checks++;
    if (da >= 0 || alog.size() != 256) begin
      errors++;
      $display("FAIL single_addrs idx=%0d got_n=%0d want_n=256", da, alog.size());
    end
    checks++;
    if (snd0_rst !== 1'b1 || busy !== 2'b00) begin
      errors++;
      $display("FAIL single_end rst=%b busy=%b want 1/00", snd0_rst, busy);
    end
  endtask

  task automatic test_both();
    int d, alt;
    romxor = 8'($urandom);
    lat    = 3;
    wr(3'd6, 8'h00);
    wr(3'd4, 8'h00);
    wr(3'd7, 8'h80);
    wr(3'd5, 8'h80);
    q0.delete();
    q1.delete();
    alog.delete();
    wr(3'd0, 8'h00);
    wr(3'd1, 8'h00);
    run_v(100, 40, 1'b0);
    wr(3'd2, 8'h00);
    wr(3'd3, 8'h00);
    tick(5);
    model(1'b0, 8'h00, 8'h00);
    d = diff4(q0, exp_nib, 40);
    checks++;
    if (d >= 0 || q0.size() != 40) begin
      errors++;
      $display("FAIL both_ch0 idx=%0d got_n=%0d want_n=40", d, q0.size());
    end
    model(1'b1, 8'h80, 8'h80);
    d = diff4(q1, exp_nib, 40);
    checks++;
    if (d >= 0 || q1.size() != 40) begin
      errors++;
      $display("FAIL both_ch1 idx=%0d got_n=%0d want_n=40", d, q1.size());
    end
    checks++;
    if (alog.size() < 2 || alog[0] !== 17'h00000 ||
        alog[1] !== 17'h18000) begin
      errors++;
      $display("FAIL both_first n=%0d got %h %h want 00000 18000",
               alog.size(),
               alog.size() > 0 ? alog[0] : 17'h0,
               alog.size() > 1 ? alog[1] : 17'h0);
    end
    alt = -1;
    for (int i = 0; i < 30; i++)
      if (alt < 0 && (i >= alog.size() || alog[i][16] !== i[0])) alt = i;
    checks++;
    if (alt >= 0) begin
      errors++;
      $display("FAIL both_alternate idx=%0d n=%0d want alternating", alt,
               alog.size());
    end
    checks++;
    if (busy !== 2'b00) begin
      errors++;
      $display("FAIL both_stop busy=%b want 00", busy);
    end
  endtask

  task automatic test_underrun();
    logic [7:0] s, b0, b1;
    s      = 8'($urandom);
    romxor = 8'($urandom);
    wr(3'd6, s);
    wr(3'd4, s);
    lat = 1000000;
    wr(3'd0, 8'h00);
    tick(10);
    strobe();
    checks++;
    if (snd0_data !== 4'h0) begin
      errors++;
      $display("FAIL underrun1 got %h want 0", snd0_data);
    end
    strobe();
    checks++;
    if (snd0_data !== 4'h0) begin
      errors++;
      $display("FAIL underrun2 got %h want 0", snd0_data);
    end
    checks++;
    if (busy[0] !== 1'b1 || rom_cs !== 1'b1 ||
        rom_addr !== {1'b0, s, 8'h00}) begin
      errors++;
      $display("FAIL underrun_hold busy=%b cs=%b addr=%h want 1/1/%h",
               busy[0], rom_cs, rom_addr, {1'b0, s, 8'h00});
    end
    b0  = rom_byte({1'b0, s, 8'h00});
    b1  = rom_byte({1'b0, s, 8'h01});
    lat = 0;
    tick(4);
    strobe();
    checks++;
    if (snd0_data !== b0[7:4]) begin
      errors++;
      $display("FAIL underrun_hi got %h want %h", snd0_data, b0[7:4]);
    end
    strobe();
    checks++;
    if (snd0_data !== b0[3:0]) begin
      errors++;
      $display("FAIL underrun_lo got %h want %h", snd0_data, b0[3:0]);
    end
    tick(6);
    strobe();
    checks++;
    if (snd0_data !== b1[7:4]) begin
      errors++;
      $display("FAIL underrun_next got %h want %h", snd0_data, b1[7:4]);
    end
    wr(3'd2, 8'h00);
    tick(2);
  endtask

  task automatic test_stop();
    logic [7:0] s;
    logic [3:0] d1;
    s = 8'($urandom);
    wr(3'd7, s);
    wr(3'd5, s);
    lat = 1000000;
    wr(3'd1, 8'h00);
    tick(5);
    checks++;
    if (rom_cs !== 1'b1 || rom_addr !== {1'b1, s, 8'h00}) begin
      errors++;
      $display("FAIL stop_pre cs=%b addr=%h want 1/%h", rom_cs, rom_addr,
               {1'b1, s, 8'h00});
    end
    d1 = snd1_data;
    wr(3'd3, 8'h00);
    checks++;
    if (snd1_rst !== 1'b1 || busy[1] !== 1'b0) begin
      errors++;
      $display("FAIL stop_rst rst=%b busy=%b want 1/0", snd1_rst, busy[1]);
    end
    checks++;
    if (rom_cs !== 1'b0) begin
      errors++;
      $display("FAIL stop_cs got %b want 0", rom_cs);
    end
    force_ok = 1'b1;
    tick(2);
    force_ok = 1'b0;
    tick(3);
    checks++;
    if (busy !== 2'b00 || snd1_data !== d1 || rom_cs !== 1'b0) begin
      errors++;
      $display("FAIL late_ok busy=%b data=%h cs=%b want 00/%h/0",
               busy, snd1_data, rom_cs, d1);
    end
    wr(3'd1, 8'h00, 1'b0);
    tick(2);
    checks++;
    if (busy !== 2'b00) begin
      errors++;
      $display("FAIL no_cen busy=%b want 00", busy);
    end
    lat = 3;
  endtask

  task automatic test_wrap();
    int d, da;
    romxor = 8'($urandom);
    lat    = 2;
    wr(3'd6, 8'hFF);
    wr(3'd4, 8'h00);
    q0.delete();
    alog.delete();
    wr(3'd0, 8'h00);
    run_v(20, 1100, 1'b1);
    model(1'b0, 8'hFF, 8'h00);
    d = diff4(q0, exp_nib, exp_nib.size());
    checks++;
    if (d >= 0 || q0.size() != 1024) begin
      errors++;
      $display("FAIL wrap_nibbles idx=%0d got_n=%0d want_n=1024", d, q0.size());
    end
    da = diff17(alog, exp_addr, exp_addr.size());
    checks++;
    if (da >= 0 || alog.size() != 512) begin
      errors++;
      $display("FAIL wrap_addrs idx=%0d got_n=%0d want_n=512", da, alog.size());
    end
    checks++;
    if (alog.size() < 257 || alog[255] !== 17'h0FFFF ||
        alog[256] !== 17'h00000) begin
      errors++;
      $display("FAIL wrap_edge n=%0d want 0FFFF then 00000", alog.size());
    end
    checks++;
    if (busy !== 2'b00) begin
      errors++;
      $display("FAIL wrap_end busy=%b want 00", busy);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] s;
    s = 8'($urandom);
    wr(3'd6, s);
    wr(3'd4, s);
    lat = 2;
    wr(3'd0, 8'h00);
    run_v(20, 30, 1'b0);
    lat = 1000000;
    strobe();
    strobe();
    tick(3);
    checks++;
    if (rom_cs !== 1'b1 || busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre cs=%b busy=%b want 1/1", rom_cs, busy[0]);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (rom_cs !== 1'b0 || rom_addr !== 17'h0) begin
      errors++;
      $display("FAIL rst_async_rom cs=%b addr=%h want 0/0", rom_cs, rom_addr);
    end
    checks++;
    if (snd0_rst !== 1'b1 || snd1_rst !== 1'b1 || busy !== 2'b00 ||
        snd0_data !== 4'h0) begin
      errors++;
      $display("FAIL rst_async_ch rst=%b%b busy=%b data=%h want 11/00/0",
               snd1_rst, snd0_rst, busy, snd0_data);
    end
    lat = 0;
    @(negedge clk);
    rst = 1'b0;
    run_v(20, 10, 1'b0);
    checks++;
    if (busy !== 2'b00 || rom_cs !== 1'b0 || snd0_rst !== 1'b1) begin
      errors++;
      $display("FAIL rst_no_resume busy=%b cs=%b rst=%b want 00/0/1",
               busy, rom_cs, snd0_rst);
    end
  endtask

  initial begin
    #20000000;
    $display("FAIL timeout reached want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_both();
    test_underrun();
    test_stop();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
